// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and default timing constants for the PS/2 host
// transmitter.
//   ps2_state_e          transmitter FSM state encoding
//   PS2_*_CYCLES_DEF     default timing values (65 MHz system clock)
//   odd_parity()         PS/2 parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int unsigned PS2_INHIBIT_CYCLES_DEF = 7150;   // 110 us
  localparam int unsigned PS2_SETUP_CYCLES_DEF   = 65;     // 1 us
  localparam int unsigned PS2_FILTER_CYCLES_DEF  = 8;
  localparam int unsigned PS2_TIMEOUT_CYCLES_DEF = 130000; // 2 ms

  // Parity bit that makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer followed by a stability filter for one
// raw PS/2 line.
//   clk, rst_n   system clock, synchronous active-low reset
//   line_in      raw asynchronous line level
//   level        filtered level; follows line_in only after FILTER_CYCLES
//                consecutive synchronized samples at the new value
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = PS2_FILTER_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // An idle PS/2 line is high, so everything resets to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_q1 <= line_in;
      sync_q2 <= sync_q1;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: PS/2 host-to-device command transmitter.
//   clk, rst_n          system clock, synchronous active-low reset
//   tx_data, tx_valid   command byte and request (accepted when tx_ready)
//   tx_ready            high only while idle
//   kclk_in, kdata_in   raw PS/2 clock/data line levels
//   kclk_oe, kdata_oe   1 = pull the line low, 0 = release
//   done                one-cycle pulse after device ACK and bus idle
//   err                 one-cycle pulse on missing ACK (or watchdog timeout)
// Optional: define PS2_TX_TIMEOUT_EN to add a frame watchdog.
//
// state     | meaning
// IDLE      | lines released, waiting for a byte
// INHIBIT   | hold clock low for INHIBIT_CYCLES
// REQ       | clock and data low (start bit) for SETUP_CYCLES
// SHIFT     | clock released; next bit driven on each device clock fall
// ACK       | data released; device ACK sampled on next clock fall
// WAIT_IDLE | wait for both lines high, then done
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int unsigned SETUP_CYCLES   = PS2_SETUP_CYCLES_DEF,
  parameter int unsigned FILTER_CYCLES  = PS2_FILTER_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       done,
  output logic       err
);

  localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  if (INHIBIT_CYCLES == 0 || SETUP_CYCLES == 0 || FILTER_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("ps2_transmitter: timing parameters must be nonzero");
  end

  ps2_state_e       state;
  ps2_state_e       state_nxt;
  logic             kclk_f;
  logic             kdata_f;
  logic             kclk_prev;
  logic             kclk_fall;
  logic             bus_idle;
  logic             tmr_zero;
  logic             wd_expired;
  logic [TMR_W-1:0] tmr;
  logic [9:0]       shreg;     // {stop, parity, data[7:0]}, shifted out LSB first
  logic             cur_bit;   // bit currently presented on the data line
  logic [3:0]       bit_cnt;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (kclk_in),
    .level   (kclk_f)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (kdata_in),
    .level   (kdata_f)
  );

  assign kclk_fall = kclk_prev & ~kclk_f;
  assign bus_idle  = kclk_f & kdata_f;
  assign tmr_zero  = (tmr == '0);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active  = (state == REQ) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  // wd_cnt is 0 in the first REQ cycle, so expiry lands on cycle TIMEOUT_CYCLES.
  assign wd_expired = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == INHIBIT && tmr_zero) begin
      wd_cnt <= '0;
    end else if (wd_active && !wd_expired) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (tx_valid) state_nxt = INHIBIT;
      INHIBIT:   if (tmr_zero) state_nxt = REQ;
      REQ: begin
        if (wd_expired)    state_nxt = IDLE;
        else if (tmr_zero) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (wd_expired)                          state_nxt = IDLE;
        else if (kclk_fall && bit_cnt == 4'd9)   state_nxt = ACK;
      end
      ACK: begin
        if (wd_expired)     state_nxt = IDLE;
        else if (kclk_fall) state_nxt = kdata_f ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (bus_idle || wd_expired) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr       <= '0;
      shreg     <= '0;
      cur_bit   <= 1'b0;
      bit_cnt   <= '0;
      kclk_prev <= 1'b1;
    end else begin
      kclk_prev <= kclk_f;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg   <= {1'b1, odd_parity(tx_data), tx_data};
            cur_bit <= 1'b0;
            bit_cnt <= '0;
            tmr     <= TMR_W'(INHIBIT_CYCLES - 1);
          end
        end
        INHIBIT: begin
          if (tmr_zero) tmr <= TMR_W'(SETUP_CYCLES - 1);
          else          tmr <= tmr - TMR_W'(1);
        end
        REQ: begin
          if (!tmr_zero) tmr <= tmr - TMR_W'(1);
        end
        SHIFT: begin
          if (kclk_fall) begin
            cur_bit <= shreg[0];
            shreg   <= {1'b0, shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_ready = 1'b0;
    kclk_oe  = 1'b0;
    kdata_oe = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      IDLE:      tx_ready = rst_n;
      INHIBIT:   kclk_oe  = 1'b1;
      REQ: begin
        kclk_oe  = 1'b1;
        kdata_oe = 1'b1;
        err      = wd_expired & rst_n;
      end
      SHIFT: begin
        kdata_oe = ~cur_bit;
        err      = wd_expired & rst_n;
      end
      ACK:       err  = ((kclk_fall & kdata_f) | wd_expired) & rst_n;
      // done takes priority so the two pulses can never coincide.
      WAIT_IDLE: begin
        done = bus_idle & rst_n;
        err  = wd_expired & ~bus_idle & rst_n;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
`timescale 1ns/1ps
module tb_ps2_transmitter;
  import ps2_pkg::*;

  localparam int INH  = 60;
  localparam int SET  = 10;
  localparam int FILT = 3;
  localparam int TMO  = 2000;
  localparam int H    = 30;   // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, kclk_oe, kdata_oe, done, err;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch_low = 1'b0;
  logic       kclk_in, kdata_in;

  // open-drain wired-AND of host and device
  assign kclk_in  = ~(kclk_oe | dev_clk_low | glitch_low);
  assign kdata_in = ~(kdata_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_transmitter #(
    .INHIBIT_CYCLES (INH),
    .SETUP_CYCLES   (SET),
    .FILTER_CYCLES  (FILT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .kclk_in  (kclk_in),
    .kdata_in (kdata_in),
    .kclk_oe  (kclk_oe),
    .kdata_oe (kdata_oe),
    .done     (done),
    .err      (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  // m_kind: 0 expect done, 1 expect NACK err, 2 expect timeout err, 3 no pulse
  int         m_busy = 0, m_end = 0, m_cyc = 0, m_kind = 0, m_pulses = 0;
  int         n_accept = 0, n_done = 0, n_err = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0;
      m_end  = 0;
      exp_q.delete();
    end else if (m_busy != 0) begin
      if (m_end != 0) begin
        m_busy = 0;
        m_end  = 0;
      end else begin
        m_cyc++;
      end
    end else if (tx_valid) begin
      m_busy   = 1;
      m_cyc    = 1;
      m_pulses = 0;
      exp_q.push_back(tx_data);
      n_accept++;
    end
    #1;
    if (!rst_n) begin
      check("reset_outputs", 32'({kclk_oe, kdata_oe, done, err, tx_ready}), 32'(5'b00000));
    end else if (m_busy == 0) begin
      check("idle_outputs", 32'({kclk_oe, kdata_oe, done, err, tx_ready}), 32'(5'b00001));
    end else begin
      check("done_err_exclusive", 32'(done & err), 32'(0));
      if (m_cyc <= INH)
        check("inhibit_phase", 32'({kclk_oe, kdata_oe, tx_ready}), 32'(3'b100));
      else if (m_cyc <= INH + SET)
        check("req_phase", 32'({kclk_oe, kdata_oe, tx_ready}), 32'(3'b110));
      else
        check("clk_released", 32'({kclk_oe, tx_ready}), 32'(2'b00));
      if (done | err) begin
        m_pulses++;
        if (done) n_done++;
        if (err)  n_err++;
        check("one_pulse_per_byte", 32'(m_pulses), 32'(1));
        check("pulse_kind", 32'({done, err}),
              32'((m_kind == 0) ? 2'b10 : (m_kind == 1 || m_kind == 2) ? 2'b01 : 2'b00));
        if (m_kind == 2) check("timeout_cycle", 32'(m_cyc), 32'(INH + TMO));
        m_end = 1;
      end
    end
  end

  // ---------------- device model ----------------
  // mode 0: ACK, 1: no ACK, 2: stop after the 4th clock fall
  task automatic dev_frame(input int mode, input bit glitch, output logic [10:0] bits);
    int t = 0;
    bits = '0;
    while (!(kclk_in === 1'b1 && kdata_in === 1'b0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("host_request_seen", 32'(t < 500), 32'(1));
    if (t >= 500) return;
    repeat (5) @(negedge clk);
    bits[0] = kdata_in;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (k <= 10) bits[k] = kdata_in;
      dev_clk_low = 1'b0;
      if (mode == 2 && k == 4) return;
      if (k == 10) begin
        repeat (H / 2) @(negedge clk);
        if (mode == 0) dev_data_low = 1'b1;
        repeat (H - H / 2) @(negedge clk);
      end else if (k == 11) begin
        repeat (H) @(negedge clk);
        dev_data_low = 1'b0;
      end else if (glitch) begin
        repeat (H / 2) @(negedge clk);
        glitch_low = 1'b1;
        repeat (FILT - 1) @(negedge clk);
        glitch_low = 1'b0;
        repeat (H - H / 2 - (FILT - 1)) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic check_frame(input logic [10:0] bits);
    logic [7:0] e;
    check("expected_byte_pending", 32'(exp_q.size() > 0), 32'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("frame_bits", 32'(bits), 32'(frame_of(e)));
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (tx_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("return_to_idle", 32'(t < 2000), 32'(1));
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [10:0] bits;
    int          d0, e0, a0, cnt;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 32'(tx_ready), 32'(1));

    // 0xED with ACK: clock hold, frame literal, single done
    m_kind = 0; d0 = n_done; e0 = n_err;
    send(8'hED);
    cnt = 0;
    while (kclk_oe === 1'b1 && cnt < 10000) begin
      cnt++;
      @(negedge clk);
    end
    check("clk_hold_cycles", 32'(cnt), 32'(INH + SET));
    dev_frame(0, 1'b0, bits);
    check_frame(bits);
    check("ED_frame_literal", 32'(bits), 32'(11'b11111011010));
    wait_ready();
    check("ED_done_once", 32'(n_done - d0), 32'(1));
    check("ED_no_err", 32'(n_err - e0), 32'(0));

    // 0x01 with sub-filter glitches on every high phase: parity 0
    m_kind = 0; d0 = n_done;
    send(8'h01);
    dev_frame(0, 1'b1, bits);
    check_frame(bits);
    check("01_parity", 32'(bits[9]), 32'(0));
    check("01_data", 32'(bits[8:1]), 32'(8'h01));
    wait_ready();
    check("01_done_once", 32'(n_done - d0), 32'(1));

    // 0xFF: parity 1
    m_kind = 0;
    send(8'hFF);
    dev_frame(0, 1'b0, bits);
    check_frame(bits);
    check("FF_parity", 32'(bits[9]), 32'(1));
    wait_ready();

    // 0x3C, device never ACKs
    m_kind = 1; d0 = n_done; e0 = n_err;
    send(8'h3C);
    dev_frame(1, 1'b0, bits);
    check_frame(bits);
    wait_ready();
    @(negedge clk);
    check("nack_err_once", 32'(n_err - e0), 32'(1));
    check("nack_no_done", 32'(n_done - d0), 32'(0));
    check("nack_idle_lines", 32'({kclk_oe, kdata_oe, tx_ready}), 32'(3'b001));

    // tx_valid held through a frame while data changes to 0x55
    m_kind = 0; a0 = n_accept;
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    repeat (20) @(negedge clk);
    tx_data = 8'h55;
    dev_frame(0, 1'b0, bits);
    check_frame(bits);
    check("held_first_byte", 32'(bits[8:1]), 32'(8'hA5));
    wait_ready();
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(0, 1'b0, bits);
    check_frame(bits);
    check("held_second_byte", 32'(bits[8:1]), 32'(8'h55));
    wait_ready();
    check("held_accept_count", 32'(n_accept - a0), 32'(2));

    // reset at bit 4 of the shift phase
    m_kind = 3; d0 = n_done; e0 = n_err;
    send(8'hA0);
    dev_frame(2, 1'b0, bits);
    repeat (3) @(negedge clk);
    check("abort_bit4_driven", 32'(kdata_oe), 32'(1));
    check("abort_bits_seen", 32'(bits[3:0]), 32'(4'b0000));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_lines_released", 32'({kclk_oe, kdata_oe, done, err}), 32'(4'b0000));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after_reset", 32'(tx_ready), 32'(1));
    check("abort_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'(0));

    // silent device
`ifdef PS2_TX_TIMEOUT_EN
    m_kind = 2; e0 = n_err;
    send(8'h5A);
    cnt = 0;
    while (n_err == e0 && cnt < INH + SET + TMO + 200) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_err_once", 32'(n_err - e0), 32'(1));
    @(negedge clk);
    check("timeout_idle_lines", 32'({kclk_oe, kdata_oe, tx_ready}), 32'(3'b001));
    exp_q.delete();
`else
    m_kind = 3; d0 = n_done; e0 = n_err;
    send(8'h5A);
    repeat (INH + SET + 2500) @(negedge clk);
    check("stall_held_in_shift", 32'({kclk_oe, kdata_oe, tx_ready}), 32'(3'b010));
    check("stall_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'(0));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("stall_recovered", 32'(tx_ready), 32'(1));
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got no completion, expected end of test");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ps2_transmitter.md
PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

Interface
REQ-001 SHALL have parameters: INHIBIT_CYCLES, default 7150, clock-hold-low time (110 us at 65 MHz); SETUP_CYCLES, default 65, data-low-before-clock-release time; FILTER_CYCLES, default 8, line-stable cycles before a level is accepted; TIMEOUT_CYCLES, default 130000, frame watchdog (2 ms).
REQ-002 clk  input  1  system clock (65 MHz); all logic on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 tx_data  input  8  command byte to send to the keyboard.
REQ-005 tx_valid  input  1  request; byte accepted on the cycle where tx_valid && tx_ready.
REQ-006 tx_ready  output  1  high only in IDLE.
REQ-007 kclk_in, kdata_in  input  1 each  raw PS/2 clock and data line levels (asynchronous).
REQ-008 kclk_oe, kdata_oe  output  1 each  1 = pull line low (open-drain), 0 = release.
REQ-009 done  output  1  one-cycle pulse after device ACK and bus idle.
REQ-010 err  output  1  one-cycle pulse on missing ACK or timeout.

Function
REQ-011 SHALL pass kclk_in and kdata_in through a 2-FF synchronizer plus a filter; the filtered level changes only after FILTER_CYCLES consecutive equal samples.
REQ-012 SHALL detect kclk falling edge as filtered previous = 1 and current = 0, one-cycle flag.
REQ-013 SHALL use states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-014 IDLE: tx_ready = 1, both oe = 0; on accept latch tx_data, compute parity = ~^tx_data (odd), go to INHIBIT next cycle.
REQ-015 INHIBIT: kclk_oe = 1, kdata_oe = 0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-016 REQ: kclk_oe = 1, kdata_oe = 1 (start bit) for exactly SETUP_CYCLES cycles, then SHIFT with kclk_oe = 0.
REQ-017 SHIFT: on each kclk falling edge drive next bit (kdata_oe = ~bit): falls 1-8 data LSB first, fall 9 parity, fall 10 stop (kdata_oe = 0), then ACK; 4-bit bit counter.
REQ-018 ACK: on next kclk falling edge, filtered kdata = 0 -> WAIT_IDLE; kdata = 1 -> err pulse, IDLE.
REQ-019 WAIT_IDLE: when filtered kclk = 1 and kdata = 1, pulse done, go IDLE.
REQ-020 tx_valid outside IDLE SHALL be ignored; no queueing.
REQ-021 done and err SHALL never assert in the same cycle; at most one per accepted byte.
REQ-022 Host SHALL never drive kclk low in SHIFT, ACK, WAIT_IDLE.

Reset
REQ-023 While rst_n = 0: state IDLE, kclk_oe = 0, kdata_oe = 0, done = 0, err = 0, tx_ready = 0; counters and filters cleared (filtered levels = 1).
REQ-024 Reset mid-frame SHALL release both lines on the first clk edge with rst_n = 0, with no done/err pulse; tx_ready = 1 first cycle after rst_n returns high.

Configuration
REQ-025 With PS2_TX_TIMEOUT_EN defined: a counter starts at INHIBIT exit, clears nowhere else; reaching TIMEOUT_CYCLES in REQ/SHIFT/ACK/WAIT_IDLE releases both lines, pulses err, returns to IDLE.
REQ-026 Without PS2_TX_TIMEOUT_EN: no watchdog logic; err only from REQ-018; a silent device holds the FSM until reset.

Structure
REQ-027 Package ps2_pkg SHALL hold the state enum type and default parameter constants (INHIBIT, SETUP, FILTER, TIMEOUT).
REQ-028 Sub-module ps2_line_filter (synchronizer + stability filter), instantiated once per line.

Verification
REQ-029 tx_data = 0xED, device model clocks 12.5 kHz and ACKs -> kclk low 7150 cycles, frame bits 0,1,0,1,1,0,1,1,1,parity 1,stop 1; done pulses once.
REQ-030 tx_data = 0x01 -> parity bit 0; tx_data = 0xFF -> parity bit 1; data captured by model matches.
REQ-031 Device leaves kdata high on 11th fall -> err pulses once, done never, both oe = 0, tx_ready = 1.
REQ-032 PS2_TX_TIMEOUT_EN defined, device never clocks -> err exactly TIMEOUT_CYCLES after INHIBIT exit; undefined -> FSM stays in SHIFT.
REQ-033 tx_valid held high through a frame with data changing to 0x55 -> only first byte sent; 0x55 accepted after return to IDLE.
REQ-034 rst_n low at bit 4 of SHIFT -> both oe = 0 next edge, no done/err; 1-cycle 0 glitches on kclk_in (< FILTER_CYCLES) produce no edge.
